ntr_cmd_capture: RTL and testbench



---
 rtl/ntr_cmd_capture.sv | 170 +++++++++++++++++
 tb/tb_ntr_cmd_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntr_cmd_capture.sv
// Purpose : synchronise the NTR cartridge pins, assemble the first 8 bytes of each frame into a 64-bit command.
// Latency : pin ntr_clk rise -> internal rise after SYNC_STAGES edges; cmd_valid on the edge after the 8th rise.
// Backpr. : single holding register; a command completing while cmd_valid is held unconsumed is dropped (err_overrun).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ntr_clk, ntr_data   asynchronous cartridge bus pins (ntr_clk idles high)
//   cmd_valid/ready/data  command handoff; byte 0 of the frame lands in cmd_data[63:56]
//   frame_active        a frame is in progress (capturing or in its data phase)
//   err_overrun, err_short  sticky error flags, cleared by clear_flags
module ntr_cmd_capture #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ntr_clk,
  input  logic [7:0]  ntr_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_data,
  output logic        frame_active,
  output logic        err_overrun,
  output logic        err_short,
  input  logic        clear_flags
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_IDLE} state_t;

  localparam logic [7:0] TMO = 8'(IDLE_TIMEOUT);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   clk_s;
  logic [7:0]             data_s;
  logic                   clk_prev;
  logic                   rise;
  logic [7:0]             idle_cnt;
  logic                   timeout;

  state_t      state, state_nxt;
  logic [2:0]  byte_cnt, cnt_nxt;
  logic [63:0] shreg, shreg_nxt;
  logic [5:0]  bit_lo;
  logic        complete;
  logic        short_set;
  logic        load;
  logic        overrun_set;

  // Pin synchronisers; the clock chain resets to its idle-high level so
  // reset release never fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      clk_sync[0]  <= ntr_clk;
      data_sync[0] <= ntr_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign rise   = clk_s & ~clk_prev;

  // Idle counter: cycles since the last rise, saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev <= 1'b1;
      idle_cnt <= '0;
    end else begin
      clk_prev <= clk_s;
      if (rise)
        idle_cnt <= '0;
      else if (idle_cnt != TMO)
        idle_cnt <= idle_cnt + 8'd1;
    end
  end

  // A rise in the saturation cycle takes precedence over the timeout.
  assign timeout = (idle_cnt == TMO) && !rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= cnt_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Byte n of the frame goes to bits [63-8n -: 8]; 7-n is ~n for 3 bits.
  assign bit_lo = {~byte_cnt, 3'b000};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    shreg_nxt = shreg;
    complete  = 1'b0;
    short_set = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          shreg_nxt        = '0;
          shreg_nxt[63:56] = data_s;
          cnt_nxt          = 3'd1;
          state_nxt        = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          shreg_nxt[bit_lo +: 8] = data_s;
          if (byte_cnt == 3'd7) begin
            complete  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_IDLE;
          end else begin
            cnt_nxt = byte_cnt + 3'd1;
          end
        end else if (timeout) begin
          short_set = 1'b1;
          cnt_nxt   = '0;
          shreg_nxt = '0;
          state_nxt = IDLE;
        end
      end
      WAIT_IDLE: begin
        // Rises here are data-phase transfers; they only keep the idle
        // counter from expiring.
        if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completion may reuse the holding register if it is empty or being
  // drained in this very cycle.
  assign load        = complete && (!cmd_valid || cmd_ready);
  assign overrun_set = complete && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd_data    <= '0;
      err_overrun <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      if (load) begin
        cmd_valid <= 1'b1;
        cmd_data  <= shreg_nxt;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (overrun_set)      err_overrun <= 1'b1;
      else if (clear_flags) err_overrun <= 1'b0;
      if (short_set)        err_short <= 1'b1;
      else if (clear_flags) err_short <= 1'b0;
    end
  end

  assign frame_active = (state != IDLE);

endmodule

// File: tb/tb_ntr_cmd_capture.sv
module tb_ntr_cmd_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ntr_clk;
  logic [7:0]  ntr_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_data;
  logic        frame_active;
  logic        err_overrun;
  logic        err_short;
  logic        clear_flags;

  logic        man_ready;
  logic        rnd_ready = 1'b1;
  logic        rnd_mode  = 1'b0;

  int total  = 0;
  int passed = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  logic        hold_vld = 1'b0;
  logic [63:0] hold_dat = '0;

  typedef struct {
    logic [127:0] bytes;
    int           n;
    logic         exp_cmd;
    logic [63:0]  exp_data;
    logic         exp_short;
  } vec_t;

  vec_t tbl[7];

  assign cmd_ready = rnd_mode ? rnd_ready : man_ready;

  ntr_cmd_capture #(.SYNC_STAGES(2), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_data(ntr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .frame_active(frame_active), .err_overrun(err_overrun),
    .err_short(err_short), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
    ntr_data = b;
    ntr_clk  = 1'b0;
    tick(lo);
    ntr_clk  = 1'b1;
    tick(hi);
    ntr_data = 8'hFF;
  endtask

  task automatic send_frame(input logic [127:0] bytes, input int n, input int lo, input int hi);
    logic [127:0] v;
    v = bytes;
    for (int i = 0; i < n; i++) send_byte(v[127-8*i -: 8], lo, hi);
  endtask

  task automatic idle(input int n);
    ntr_clk = 1'b1;
    tick(n);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    tick(1);
  endtask

  // Consumer side: collect every handshake and require a held command to
  // stay put until it is taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) chk("held_data_stable", cmd_data, hold_dat);
      if (cmd_valid && cmd_ready) got_q.push_back(cmd_data);
      hold_vld = cmd_valid && !cmd_ready;
      hold_dat = cmd_data;
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #2;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{128'hB7000000_00000000_00000000_00000000, 8,  1'b1, 64'hB700_0000_0000_0000, 1'b0};
    tbl[1] = '{128'h01020300_00000000_00000000_00000000, 3,  1'b0, 64'h0,                   1'b1};
    tbl[2] = '{128'h9F000000_00000000_00000000_00000000, 8,  1'b1, 64'h9F00_0000_0000_0000, 1'b0};
    tbl[3] = '{128'h01234567_89ABCDEF_FEDCBA98_00000000, 10, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
    tbl[4] = '{128'h5A000000_00000000_00000000_00000000, 1,  1'b0, 64'h0,                   1'b1};
    tbl[5] = '{128'h11223344_55667700_00000000_00000000, 7,  1'b0, 64'h0,                   1'b1};
    tbl[6] = '{128'hFFFFFFFF_FFFFFFFF_00000000_00000000, 8,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    rst_n       = 1'b0;
    ntr_clk     = 1'b1;
    ntr_data    = 8'hFF;
    man_ready   = 1'b1;
    clear_flags = 1'b0;
    tick(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_err_overrun", err_overrun, 0);
    chk("rst_err_short", err_short, 0);
    rst_n = 1'b1;
    tick(2);

    // Frame table: one frame per record, ready always high.
    for (int t = 0; t < 7; t++) begin
      got_q.delete();
      send_frame(tbl[t].bytes, tbl[t].n, 4, 4);
      tick(3);
      chk($sformatf("tbl%0d_active_in_frame", t), frame_active, 1);
      idle(25);
      chk($sformatf("tbl%0d_active_after_idle", t), frame_active, 0);
      chk($sformatf("tbl%0d_cmd_count", t), got_q.size(), tbl[t].exp_cmd ? 1 : 0);
      if (got_q.size() > 0 && tbl[t].exp_cmd)
        chk($sformatf("tbl%0d_cmd_data", t), got_q[0], tbl[t].exp_data);
      chk($sformatf("tbl%0d_err_short", t), err_short, tbl[t].exp_short);
      chk($sformatf("tbl%0d_err_overrun", t), err_overrun, 0);
      pulse_clear();
      chk($sformatf("tbl%0d_short_cleared", t), err_short, 0);
    end

    // Data phase: 24 rises, only the first 8 form the command; frame_active
    // drops exactly 17 cycles after the last internal rise.
    got_q.delete();
    for (int i = 0; i < 24; i++) send_byte(8'(8'hC0 + i), 5, 5);
    chk("dp_cmd_count_early", got_q.size(), 1);
    tick(14);
    chk("dp_active_before_timeout", frame_active, 1);
    tick(1);
    chk("dp_active_after_timeout", frame_active, 0);
    chk("dp_cmd_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("dp_cmd_data", got_q[0], 64'hC0C1_C2C3_C4C5_C6C7);
    chk("dp_err_short", err_short, 0);
    idle(5);

    // Rise gap of 17 lands on the timeout cycle and is accepted; 18 is not.
    got_q.delete();
    send_frame(128'hD0D1D2D3_D4D5D6D7_00000000_00000000, 8, 8, 9);
    idle(25);
    chk("bnd17_cmd_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("bnd17_cmd_data", got_q[0], 64'hD0D1_D2D3_D4D5_D6D7);
    chk("bnd17_err_short", err_short, 0);
    send_frame(128'h12340000_00000000_00000000_00000000, 2, 9, 9);
    idle(25);
    chk("bnd18_err_short", err_short, 1);
    chk("bnd18_cmd_count", got_q.size(), 1);
    pulse_clear();

    // Backpressure: second command dropped, first held unchanged.
    got_q.delete();
    man_ready = 1'b0;
    send_frame(128'hA1A2A3A4_A5A6A7A8_00000000_00000000, 8, 4, 4);
    idle(25);
    chk("bp_valid_first", cmd_valid, 1);
    chk("bp_data_first", cmd_data, 64'hA1A2_A3A4_A5A6_A7A8);
    chk("bp_no_overrun_yet", err_overrun, 0);
    send_frame(128'hB1B2B3B4_B5B6B7B8_00000000_00000000, 8, 4, 4);
    idle(25);
    chk("bp_valid_held", cmd_valid, 1);
    chk("bp_data_held", cmd_data, 64'hA1A2_A3A4_A5A6_A7A8);
    chk("bp_overrun_set", err_overrun, 1);
    man_ready = 1'b1;
    tick(1);
    man_ready = 1'b0;
    chk("bp_valid_dropped", cmd_valid, 0);
    chk("bp_delivered_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("bp_delivered_data", got_q[0], 64'hA1A2_A3A4_A5A6_A7A8);
    chk("bp_overrun_sticky", err_overrun, 1);
    pulse_clear();
    chk("bp_overrun_cleared", err_overrun, 0);

    // Handshake in the same cycle as a completion: new command loads, no overrun.
    got_q.delete();
    send_frame(128'hC1C2C3C4_C5C6C7C8_00000000_00000000, 8, 4, 4);
    idle(25);
    send_frame(128'hE0E1E2E3_E4E5E6E7_00000000_00000000, 7, 4, 4);
    ntr_data = 8'hE7;
    ntr_clk  = 1'b0;
    tick(4);
    ntr_clk  = 1'b1;
    tick(2);
    man_ready = 1'b1;
    tick(1);
    man_ready = 1'b0;
    chk("hs_valid", cmd_valid, 1);
    chk("hs_new_data", cmd_data, 64'hE0E1_E2E3_E4E5_E6E7);
    chk("hs_no_overrun", err_overrun, 0);
    chk("hs_old_taken", got_q.size(), 1);
    if (got_q.size() > 0) chk("hs_old_data", got_q[0], 64'hC1C2_C3C4_C5C6_C7C8);
    idle(25);
    man_ready = 1'b1;
    tick(2);
    chk("hs_drained", got_q.size(), 2);

    // Reset in the middle of a frame, ntr_clk low across release.
    got_q.delete();
    send_frame(128'h0A0B0C0D_0E000000_00000000_00000000, 5, 4, 4);
    ntr_clk = 1'b0;
    rst_n   = 1'b0;
    tick(2);
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_cmd_data", cmd_data, 0);
    chk("mid_rst_frame_active", frame_active, 0);
    chk("mid_rst_err_short", err_short, 0);
    chk("mid_rst_err_overrun", err_overrun, 0);
    rst_n = 1'b1;
    got_q.delete();
    send_frame(128'h90112233_44556677_00000000_00000000, 8, 4, 4);
    idle(25);
    chk("post_rst_cmd_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_rst_cmd_data", got_q[0], 64'h9011_2233_4455_6677);
    chk("post_rst_err_short", err_short, 0);

    // Randomized frames against a frame-level model: a frame of 8 or more
    // bytes yields its first 8 bytes as a command, a shorter one sets err_short.
    got_q.delete();
    exp_q.delete();
    rnd_mode = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int          len;
      logic [63:0] first8;
      len    = $urandom_range(1, 20);
      first8 = '0;
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (i < 8) first8[63-8*i -: 8] = b;
        send_byte(b, $urandom_range(3, 14), 3);
      end
      if (len >= 8) exp_q.push_back(first8);
      tick(1);
      chk($sformatf("rnd%0d_active", f), frame_active, 1);
      idle(20 + $urandom_range(0, 10));
      chk($sformatf("rnd%0d_idle", f), frame_active, 0);
      chk($sformatf("rnd%0d_err_short", f), err_short, (len < 8) ? 1 : 0);
      pulse_clear();
    end
    rnd_mode  = 1'b0;
    man_ready = 1'b1;
    tick(3);
    chk("rnd_cmd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_cmd%0d", i), got_q[i], exp_q[i]);
    chk("rnd_err_overrun", err_overrun, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
